// File: rtl/bcd_to_bin32.sv
// Sequential packed-BCD to binary converter using Horner accumulation,
// one digit per clock from the most significant nibble down.
module bcd_to_bin32 #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned OUT_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      bin_out,
    output logic                  err
);

    localparam int unsigned SR_W  = 4 * DIGITS;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sticky_q, sticky_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [OUT_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;

    logic [3:0]         digit;
    logic               digit_bad;
    logic [3:0]         digit_eff;
    logic [OUT_W-1:0]   acc_step;
    logic               sticky_step;

    // Horner step: acc*10 + digit, with an invalid nibble contributing zero.
    always_comb begin
        digit       = sr_q[SR_W-1 -: 4];
        digit_bad   = (digit > 4'd9);
        digit_eff   = digit_bad ? 4'd0 : digit;
        acc_step    = (acc_q << 3) + (acc_q << 1) + OUT_W'(digit_eff);
        sticky_step = sticky_q | digit_bad;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bin_d    = bin_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d     = bcd_in;
                    acc_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CNT_W'(DIGITS - 1);
                    busy_d   = 1'b1;
                    state_d  = CONVERT;
                end
            end
            CONVERT: begin
                acc_d    = acc_step;
                sr_d     = {sr_q[SR_W-5:0], 4'h0};
                cnt_d    = cnt_q - CNT_W'(1);
                sticky_d = sticky_step;
                // Final digit: publish the freshly computed value on this same edge.
                if (cnt_q == '0) begin
                    bin_d   = acc_step;
                    err_d   = sticky_step;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bin_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bin_q    <= bin_d;
            err_q    <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_q;
    assign err     = err_q;

endmodule
